hist_shift_search: RTL

//  Per-frame AWB histogram alignment engine. Slides one channel's histogram (R or B, chosen per run)

---
 rtl/hist_shift_search_if.sv | 48 ++++
 rtl/hist_shift_search.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hist_shift_search_if.sv
// Histogram alignment engine bus: run control, results and the shared
// read port of the three histogram RAMs.
// Optional debug signals exist only when HIST_SHIFT_DBG_EN is defined.
interface hist_shift_search_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 8,
  parameter int ACC_W  = 32
);
  logic              i_start;
  logic              i_abort;
  logic              i_mv_ch;
  logic              o_rd_en;
  logic [AW-1:0]     o_r_addr;
  logic [AW-1:0]     o_g_addr;
  logic [AW-1:0]     o_b_addr;
  logic [DATA_W-1:0] i_r_dout;
  logic [DATA_W-1:0] i_g_dout;
  logic [DATA_W-1:0] i_b_dout;
  logic              o_busy;
  logic              o_done;
  logic [ACC_W-1:0]  o_best_area;
  logic [AW:0]       o_best_shift;
`ifdef HIST_SHIFT_DBG_EN
  logic              o_dbg_valid;
  logic [AW:0]       o_dbg_shift;
  logic [ACC_W-1:0]  o_dbg_area;
`endif

  // Engine side.
  modport slave (
    input  i_start, i_abort, i_mv_ch, i_r_dout, i_g_dout, i_b_dout,
    output o_rd_en, o_r_addr, o_g_addr, o_b_addr,
           o_busy, o_done, o_best_area, o_best_shift
`ifdef HIST_SHIFT_DBG_EN
  , output o_dbg_valid, o_dbg_shift, o_dbg_area
`endif
  );

  // Controller / RAM side.
  modport master (
    output i_start, i_abort, i_mv_ch, i_r_dout, i_g_dout, i_b_dout,
    input  o_rd_en, o_r_addr, o_g_addr, o_b_addr,
           o_busy, o_done, o_best_area, o_best_shift
`ifdef HIST_SHIFT_DBG_EN
  , input  o_dbg_valid, o_dbg_shift, o_dbg_area
`endif
  );
endinterface

// File: rtl/hist_shift_search.sv
// AWB histogram alignment engine. Slides the R or B histogram across
// -MAX_SHIFT..+MAX_SHIFT (step STEP) against the other two channels and
// reports the shift maximising sum(min(r,g,b)).
// Optional: HIST_SHIFT_DBG_EN exposes each evaluated shift and its area.
//
// state  | meaning
// IDLE   | waiting for start
// SWEEP  | issuing reads for bins 0..BINS-1 of the current shift
// FLUSH  | RD_LAT+1 cycles draining the read pipeline into the accumulator
// EVAL   | compare area against best, step to next shift or finish
// DONE   | one-cycle done pulse, results published
module hist_shift_search #(
  parameter int DATA_W    = 32,
  parameter int BINS      = 256,
  parameter int STEP      = 4,
  parameter int MAX_SHIFT = 8,
  parameter int RD_LAT    = 1,
  parameter int ACC_W     = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  hist_shift_search_if.slave   bus
);
  localparam int AW = $clog2(BINS);
  localparam int FW = $clog2(RD_LAT + 1) + 1;
  localparam logic signed [AW:0] S_MAX  = (AW+1)'(MAX_SHIFT);
  localparam logic signed [AW:0] S_MIN  = -S_MAX;
  localparam logic signed [AW:0] S_STEP = (AW+1)'(STEP);

  typedef enum logic [2:0] {IDLE, SWEEP, FLUSH, EVAL, DONE} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      k_q, k_d;
  logic signed [AW:0] s_q, s_d;
  logic [FW-1:0]      flush_q, flush_d;
  logic               mv_ch_q, mv_ch_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   best_area_q, best_area_d;
  logic [AW:0]        best_shift_q, best_shift_d;
  logic [ACC_W-1:0]   out_area_q, out_area_d;
  logic [AW:0]        out_shift_q, out_shift_d;
  logic [RD_LAT-1:0]  vld_q, vld_d;
  logic [RD_LAT-1:0]  oor_q, oor_d;

  logic [AW+1:0]      idx_w;
  logic               oor;
  logic               rd_en;
  logic [DATA_W-1:0]  min_v;
  logic [ACC_W:0]     sum_w;
  logic               take;

  // Moving-channel index k-s; out of range when negative or >= BINS.
  assign idx_w = {2'b00, k_q} - {s_q[AW], s_q};
  assign oor   = idx_w[AW+1] | idx_w[AW];
  assign rd_en = (state_q == SWEEP);

  assign bus.o_rd_en      = rd_en;
  assign bus.o_g_addr     = k_q;
  assign bus.o_r_addr     = mv_ch_q ? k_q : idx_w[AW-1:0];
  assign bus.o_b_addr     = mv_ch_q ? idx_w[AW-1:0] : k_q;
  assign bus.o_busy       = (state_q != IDLE);
  assign bus.o_done       = (state_q == DONE);
  assign bus.o_best_area  = out_area_q;
  assign bus.o_best_shift = out_shift_q;
`ifdef HIST_SHIFT_DBG_EN
  assign bus.o_dbg_valid  = (state_q == EVAL);
  assign bus.o_dbg_shift  = s_q;
  assign bus.o_dbg_area   = acc_q;
`endif

  // Min of the three returned counts; an out-of-range moving bin reads as 0.
  always_comb begin
    min_v = bus.i_r_dout;
    if (bus.i_g_dout < min_v) min_v = bus.i_g_dout;
    if (bus.i_b_dout < min_v) min_v = bus.i_b_dout;
    if (oor_q[RD_LAT-1]) min_v = '0;
    sum_w = {1'b0, acc_q} + (ACC_W+1)'(min_v);
    take  = (s_q == S_MIN) || (acc_q > best_area_q);
  end

  // Next-state, counters, pipeline and accumulate logic.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    s_d          = s_q;
    flush_d      = flush_q;
    mv_ch_d      = mv_ch_q;
    acc_d        = acc_q;
    best_area_d  = best_area_q;
    best_shift_d = best_shift_q;
    out_area_d   = out_area_q;
    out_shift_d  = out_shift_q;
    vld_d        = vld_q;
    oor_d        = oor_q;

    vld_d[0] = rd_en;
    oor_d[0] = oor;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      oor_d[i] = oor_q[i-1];
    end

    if (vld_q[RD_LAT-1])
      acc_d = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];

    case (state_q)
      IDLE: begin
        if (bus.i_start && !bus.i_abort) begin
          mv_ch_d = bus.i_mv_ch;
          s_d     = S_MIN;
          k_d     = '0;
          acc_d   = '0;
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        k_d = k_q + 1'b1;
        if (k_q == AW'(BINS - 1)) begin
          flush_d = FW'(RD_LAT);
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        flush_d = flush_q - 1'b1;
        if (flush_q == '0) state_d = EVAL;
      end
      EVAL: begin
        if (take) begin
          best_area_d  = acc_q;
          best_shift_d = s_q;
        end
        if (s_q == S_MAX) begin
          out_area_d  = take ? acc_q : best_area_q;
          out_shift_d = take ? s_q : best_shift_q;
          state_d     = DONE;
        end else begin
          s_d     = s_q + S_STEP;
          k_d     = '0;
          acc_d   = '0;
          state_d = SWEEP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.i_abort) begin
      state_d = IDLE;
      vld_d   = '0;
    end
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      s_q          <= '0;
      flush_q      <= '0;
      mv_ch_q      <= 1'b0;
      acc_q        <= '0;
      best_area_q  <= '0;
      best_shift_q <= '0;
      out_area_q   <= '0;
      out_shift_q  <= '0;
      vld_q        <= '0;
      oor_q        <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      s_q          <= s_d;
      flush_q      <= flush_d;
      mv_ch_q      <= mv_ch_d;
      acc_q        <= acc_d;
      best_area_q  <= best_area_d;
      best_shift_q <= best_shift_d;
      out_area_q   <= out_area_d;
      out_shift_q  <= out_shift_d;
      vld_q        <= vld_d;
      oor_q        <= oor_d;
    end
  end
endmodule
